// File: rtl/period_ctrl_pkg.sv
// Shared types and helpers for the button-driven period controller.
package period_ctrl_pkg;

    // Default width of the period word fed to the variable clock divider
    localparam int PERIOD_W_DEF = 32;

    // Step-acceptance states: accept steps, or drop them until the window ends
    typedef enum logic {
        IDLE    = 1'b0,
        HOLDOFF = 1'b1
    } state_t;

    // Number of bits needed to hold a level index in 0..n-1 (never below 1)
    function automatic int level_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/period_ctrl_if.sv
// Button-pulse inputs and period/run outputs of the period controller.
// master: the side producing the pulses and consuming period/run.
// slave:  the period controller itself.
interface period_ctrl_if #(
    parameter int PERIOD_W = 32,
    parameter int LEVEL_W  = 3
);
    logic                up_pulse;
    logic                down_pulse;
    logic                run_toggle;
    logic [PERIOD_W-1:0] period;
    logic [LEVEL_W-1:0]  level;
    logic                running;
    logic                changed;

    modport master (
        output up_pulse, down_pulse, run_toggle,
        input  period, level, running, changed
    );

    modport slave (
        input  up_pulse, down_pulse, run_toggle,
        output period, level, running, changed
    );
endinterface

// File: rtl/period_ctrl_holdoff.sv
// Hold-off window timer: a loadable down-counter. start loads CYCLES,
// busy is high while the count is non-zero and last marks the final
// count. With CYCLES=0 the timer is absent and never busy.
module period_ctrl_holdoff #(
    parameter int CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic last
);

    if (CYCLES == 0) begin : g_off
        logic unused_inputs;
        assign unused_inputs = ^{clk, rst, start};
        assign busy = 1'b0;
        assign last = 1'b0;
    end else begin : g_on
        localparam int CW = $clog2(CYCLES + 1);
        logic [CW-1:0] count;

        // Load the window length on start, otherwise count down to zero
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                count <= '0;
            end else if (start) begin
                count <= CW'(CYCLES);
            end else if (count != '0) begin
                count <= count - CW'(1);
            end
        end

        assign busy = (count != '0);
        assign last = (count == CW'(1));
    end

endmodule

// File: rtl/period_ctrl.sv
// Period controller: turns faster/slower/run-stop press pulses into a step
// level, a registered period word (BASE_PERIOD << level) and a run flag.
// Accepted steps open a hold-off window in which further steps are dropped.
// Optional build macro PERIOD_CTRL_WRAP_EN: stepping past either end wraps
// to the other end instead of saturating.
module period_ctrl
    import period_ctrl_pkg::*;
#(
    parameter int PERIOD_W       = PERIOD_W_DEF,
    parameter int NUM_LEVELS     = 8,
    parameter int BASE_PERIOD    = 1000,
    parameter int RESET_LEVEL    = 0,
    parameter int HOLDOFF_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst,
    period_ctrl_if.slave bus
);

    localparam int                  LW       = level_width(NUM_LEVELS);
    localparam logic [LW-1:0]       MAX_LVL  = LW'(NUM_LEVELS - 1);
    localparam logic [LW-1:0]       RST_LVL  = LW'(RESET_LEVEL);
    localparam logic [PERIOD_W-1:0] BASE_VEC = PERIOD_W'(BASE_PERIOD);
    localparam bit                  HO_EN    = (HOLDOFF_CYCLES > 0);

    if (NUM_LEVELS < 2 || NUM_LEVELS > 16) begin : g_bad_levels
        $fatal(1, "period_ctrl: NUM_LEVELS must be within 2..16");
    end
    if (RESET_LEVEL < 0 || RESET_LEVEL >= NUM_LEVELS) begin : g_bad_reset_level
        $fatal(1, "period_ctrl: RESET_LEVEL must be below NUM_LEVELS");
    end
    if (BASE_PERIOD < 1 || $clog2(BASE_PERIOD + 1) + NUM_LEVELS - 1 > PERIOD_W) begin : g_bad_period
        $fatal(1, "period_ctrl: BASE_PERIOD << (NUM_LEVELS-1) does not fit PERIOD_W");
    end
    if (HOLDOFF_CYCLES < 0) begin : g_bad_holdoff
        $fatal(1, "period_ctrl: HOLDOFF_CYCLES must not be negative");
    end

    state_t              state_q;
    logic [LW-1:0]       level_q;
    logic [PERIOD_W-1:0] period_q;
    logic                running_q;
    logic                changed_q;
    logic                step_pend_q;

    logic                up_req;
    logic                down_req;
    logic                at_max;
    logic                at_min;
    logic                accept;
    logic [LW-1:0]       next_level;
    logic                ho_busy;
    logic                ho_last;

    // Decode step requests and decide whether this cycle's step is taken
    always_comb begin
        up_req     = bus.up_pulse & ~bus.down_pulse;
        down_req   = bus.down_pulse & ~bus.up_pulse;
        at_max     = (level_q == MAX_LVL);
        at_min     = (level_q == '0);
        accept     = 1'b0;
        next_level = level_q;
        if (state_q == IDLE) begin
            if (up_req) begin
`ifdef PERIOD_CTRL_WRAP_EN
                accept     = 1'b1;
                next_level = at_max ? '0 : level_q + LW'(1);
`else
                if (!at_max) begin
                    accept     = 1'b1;
                    next_level = level_q + LW'(1);
                end
`endif
            end else if (down_req) begin
`ifdef PERIOD_CTRL_WRAP_EN
                accept     = 1'b1;
                next_level = at_min ? MAX_LVL : level_q - LW'(1);
`else
                if (!at_min) begin
                    accept     = 1'b1;
                    next_level = level_q - LW'(1);
                end
`endif
            end
        end
    end

    period_ctrl_holdoff #(
        .CYCLES (HOLDOFF_CYCLES)
    ) u_holdoff (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .busy  (ho_busy),
        .last  (ho_last)
    );

    // Step FSM plus registered level, period, run flag and change strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            level_q     <= RST_LVL;
            period_q    <= BASE_VEC << RST_LVL;
            running_q   <= 1'b1;
            changed_q   <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            running_q   <= running_q ^ bus.run_toggle;
            level_q     <= next_level;
            period_q    <= BASE_VEC << level_q;
            step_pend_q <= accept;
            changed_q   <= step_pend_q;
            case (state_q)
                IDLE: begin
                    if (accept && HO_EN) begin
                        state_q <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (ho_last || !ho_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.period  = period_q;
    assign bus.level   = level_q;
    assign bus.running = running_q;
    assign bus.changed = changed_q;

endmodule

// File: tb/tb_period_ctrl.sv
// Bench for period_ctrl with BASE_PERIOD=4, NUM_LEVELS=4, RESET_LEVEL=1,
// HOLDOFF_CYCLES=3. Honours PERIOD_CTRL_WRAP_EN when building the DUT.
module tb_period_ctrl;

    typedef struct {
        logic [31:0] period;
        logic [31:0] level;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t exp_q[$];

    period_ctrl_if #(.PERIOD_W(32), .LEVEL_W(2)) bus ();

    period_ctrl #(
        .PERIOD_W       (32),
        .NUM_LEVELS     (4),
        .BASE_PERIOD    (4),
        .RESET_LEVEL    (1),
        .HOLDOFF_CYCLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and record the result
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare the full visible output state
    task automatic checkOutput(input string name, input int per, input int lvl,
                               input int run, input int chg);
        checkVal({name, ".period"},  bus.period,         per);
        checkVal({name, ".level"},   32'(bus.level),     lvl);
        checkVal({name, ".running"}, 32'(bus.running),   run);
        checkVal({name, ".changed"}, 32'(bus.changed),   chg);
    endtask

    // Drive quiet inputs for n clock edges
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
        end
    endtask

    // One-edge pulse, then check level/period/running right after that edge;
    // an accepted step queues its expected strobe for the monitor
    task automatic applyStimulus(input string name, input logic u, input logic d, input logic t,
                                 input int lvl, input int per, input int run,
                                 input bit push, input int push_per);
        exp_t e;
        bus.up_pulse   = u;
        bus.down_pulse = d;
        bus.run_toggle = t;
        if (push) begin
            e.period = push_per;
            e.level  = lvl;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.up_pulse   = 1'b0;
        bus.down_pulse = 1'b0;
        bus.run_toggle = 1'b0;
        checkVal({name, ".level"},   32'(bus.level),   lvl);
        checkVal({name, ".period"},  bus.period,       per);
        checkVal({name, ".running"}, 32'(bus.running), run);
    endtask

    // Monitor: every change strobe must match the oldest expected step
    always @(negedge clk) begin
        exp_t e;
        if (bus.changed === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_changed: got changed=1 period=%0d expected no strobe",
                         bus.period);
            end else begin
                e = exp_q.pop_front();
                checkVal("strobe.period", bus.period,     e.period);
                checkVal("strobe.level",  32'(bus.level), e.level);
            end
        end
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.up_pulse   = 1'b0;
        bus.down_pulse = 1'b0;
        bus.run_toggle = 1'b0;

        // Reset values, then asynchronous re-assertion between edges
        idle(2);
        checkOutput("in_reset", 8, 1, 1, 0);
        rst = 1'b0;
        idle(2);
        checkOutput("after_release", 8, 1, 1, 0);
        applyStimulus("t1_up", 1, 0, 0, 2, 8, 1, 1, 16);
        idle(5);
        #1 rst = 1'b1;
        #1 checkOutput("async_reset", 8, 1, 1, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Accepted step timing and hold-off window
        applyStimulus("t2_up",     1, 0, 0, 2, 8,  1, 1, 16);
        applyStimulus("t3_drop1",  1, 0, 0, 2, 16, 1, 0, 0);
        idle(1);
        checkOutput("t2_changed_low", 16, 2, 1, 0);
        applyStimulus("t3_drop2",  1, 0, 0, 2, 16, 1, 0, 0);
        applyStimulus("t3_accept", 1, 0, 0, 3, 16, 1, 1, 32);
        idle(4);

        // Upper end: wrap or saturate
`ifdef PERIOD_CTRL_WRAP_EN
        applyStimulus("t4_wrap_up",   1, 0, 0, 0, 32, 1, 1, 4);
        idle(4);
        applyStimulus("t4_wrap_down", 0, 1, 0, 3, 4,  1, 1, 32);
        idle(4);
        applyStimulus("t4_down",      0, 1, 0, 2, 32, 1, 1, 16);
        idle(4);
`else
        applyStimulus("t4_sat_up",    1, 0, 0, 3, 32, 1, 0, 0);
        checkOutput("t4_sat_state", 32, 3, 1, 0);
        applyStimulus("t4_no_holdoff", 0, 1, 0, 2, 32, 1, 1, 16);
        idle(4);
`endif
        applyStimulus("t4_down_to1", 0, 1, 0, 1, 16, 1, 1, 8);
        idle(4);
`ifndef PERIOD_CTRL_WRAP_EN
        applyStimulus("down_to0",     0, 1, 0, 0, 8, 1, 1, 4);
        idle(4);
        applyStimulus("sat_down",     0, 1, 0, 0, 4, 1, 0, 0);
        applyStimulus("up_after_sat", 1, 0, 0, 1, 4, 1, 1, 8);
        idle(4);
`endif

        // Simultaneous up and down: no step, no hold-off
        applyStimulus("t5_both", 1, 1, 0, 1, 8, 1, 0, 0);
        applyStimulus("t5_down", 0, 1, 0, 0, 8, 1, 1, 4);
        idle(4);

        // Run toggle during hold-off, then reset aborting a window
        applyStimulus("t6_up",     1, 0, 0, 1, 4,  1, 1, 8);
        applyStimulus("t6_tog1",   0, 0, 1, 1, 8,  0, 0, 0);
        applyStimulus("t6_tog2",   0, 0, 1, 1, 8,  1, 0, 0);
        applyStimulus("t6_drop",   1, 0, 0, 1, 8,  1, 0, 0);
        applyStimulus("t6_accept", 1, 0, 0, 2, 8,  1, 1, 16);
        applyStimulus("t6_tog3",   0, 0, 1, 2, 16, 0, 0, 0);
        #2 rst = 1'b1;
        #1 checkOutput("t6_reset", 8, 1, 1, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("t6_after_rst", 1, 0, 0, 2, 8, 1, 1, 16);
        idle(5);

        checkVal("pending_strobes", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
